// File: rtl/alu_addsub_serial.sv
// Multi-cycle add/subtract unit: one SLICE-bit carry-select slice per clock, LSB slice first.
// Slice carry is chained through a register; carry-out and signed overflow come from the top slice.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one slice per edge, idx selects the result slice being written
// DONE  | one-cycle result-valid pulse; a new start may be accepted here
module alu_addsub_serial #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] data_result,
    output logic             cout,
    output logic             overflow
);

    localparam int N     = WIDTH / SLICE;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic               carry;
    logic [IDX_W-1:0]   idx;

    logic [SLICE-1:0]   sl_a;
    logic [SLICE-1:0]   sl_b;
    logic [SLICE:0]     sum_c0;
    logic [SLICE:0]     sum_c1;
    logic [SLICE:0]     sum_sel;
    logic [SLICE-1:0]   sl_s;
    logic               sl_cout;
    logic               sl_ovf;

    // Operands shift right each RUN cycle, so the active slice is always the low SLICE bits.
    assign sl_a    = op_a[SLICE-1:0];
    assign sl_b    = op_b[SLICE-1:0];
    assign sum_c0  = {1'b0, sl_a} + {1'b0, sl_b};
    assign sum_c1  = {1'b0, sl_a} + {1'b0, sl_b} + {{SLICE{1'b0}}, 1'b1};
    assign sum_sel = carry ? sum_c1 : sum_c0;
    assign sl_s    = sum_sel[SLICE-1:0];
    assign sl_cout = sum_sel[SLICE];
    assign sl_ovf  = (sl_a[SLICE-1] == sl_b[SLICE-1]) && (sl_s[SLICE-1] != sl_a[SLICE-1]);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            op_a        <= '0;
            op_b        <= '0;
            carry       <= 1'b0;
            idx         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            data_result <= '0;
            cout        <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_a        <= data_operandA;
                        op_b        <= data_operandB ^ {WIDTH{sub}};
                        carry       <= sub;
                        idx         <= '0;
                        data_result <= '0;
                        cout        <= 1'b0;
                        overflow    <= 1'b0;
                        busy        <= 1'b1;
                        state       <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    for (int i = 0; i < N; i++) begin
                        if (idx == IDX_W'(i)) data_result[i*SLICE +: SLICE] <= sl_s;
                    end
                    carry <= sl_cout;
                    idx   <= idx + 1'b1;
                    op_a  <= op_a >> SLICE;
                    op_b  <= op_b >> SLICE;
                    if (idx == IDX_W'(N-1)) begin
                        cout     <= sl_cout;
                        overflow <= sl_ovf;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_addsub_serial.sv
// Bench for alu_addsub_serial: cycle-level reference model plus directed vectors with literal results.
module tb_alu_addsub_serial;

    localparam int WIDTH = 32;
    localparam int N     = 4;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        sub = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done, cout, overflow;
    logic [31:0] data_result;

    int n_tests = 0;
    int n_fail  = 0;

    alu_addsub_serial #(.WIDTH(WIDTH), .SLICE(8)) dut (
        .clock         (clock),
        .resetn        (resetn),
        .start         (start),
        .data_operandA (a),
        .data_operandB (b),
        .sub           (sub),
        .busy          (busy),
        .done          (done),
        .data_result   (data_result),
        .cout          (cout),
        .overflow      (overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // {overflow, cout, result} from plain wide arithmetic
    function automatic logic [33:0] ref_op(input logic [31:0] x, input logic [31:0] y, input logic s);
        logic [31:0] yx;
        logic [32:0] sum;
        logic        ovf;
        yx  = y ^ {32{s}};
        sum = {1'b0, x} + {1'b0, yx} + {32'd0, s};
        ovf = (x[31] == yx[31]) && (sum[31] != x[31]);
        return {ovf, sum[32], sum[31:0]};
    endfunction

    // Timing model: an accepted start gives N busy cycles, then one done cycle.
    int          m_cnt;
    logic        m_done;
    logic [31:0] m_res;
    logic        m_cout, m_ovf;
    logic [33:0] m_pend;

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            m_cnt  <= 0;
            m_done <= 1'b0;
            m_res  <= '0;
            m_cout <= 1'b0;
            m_ovf  <= 1'b0;
            m_pend <= '0;
        end else if (m_cnt == 0) begin
            m_done <= 1'b0;
            if (start) begin
                m_pend <= ref_op(a, b, sub);
                m_cnt  <= N;
                m_res  <= '0;
                m_cout <= 1'b0;
                m_ovf  <= 1'b0;
            end
        end else begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_done <= 1'b1;
                {m_ovf, m_cout, m_res} <= m_pend;
            end
        end
    end

    always @(negedge clock) begin
        check("busy", {31'd0, busy}, {31'd0, (m_cnt != 0)});
        check("done", {31'd0, done}, {31'd0, m_done});
        if (m_cnt == 0) begin
            check("model_result", data_result, m_res);
            check("model_cout", {31'd0, cout}, {31'd0, m_cout});
            check("model_ovf", {31'd0, overflow}, {31'd0, m_ovf});
        end
    end

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!done && cyc < 20) begin
            @(negedge clock);
            cyc++;
        end
    endtask

    task automatic run_op(input string name, input logic [31:0] x, input logic [31:0] y, input logic s,
                          input logic [31:0] e_res, input logic e_cout, input logic e_ovf);
        int cyc;
        @(negedge clock);
        a = x; b = y; sub = s; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_done(cyc);
        check({name, "_latency"}, cyc, 32'd5);
        check({name, "_result"}, data_result, e_res);
        check({name, "_cout"}, {31'd0, cout}, {31'd0, e_cout});
        check({name, "_ovf"}, {31'd0, overflow}, {31'd0, e_ovf});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int pulses;
        logic [31:0] r;

        #12;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", data_result, 32'd0);
        #11 resetn = 1'b1;

        run_op("t1_carry_chain", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
        run_op("t2_pos_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        run_op("t3_sub_borrow", 32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_op("t3_sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        run_op("sub_multi", 32'h1234_5678, 32'h0FED_CBA9, 1'b1, 32'h0246_8ACF, 1'b1, 1'b0);

        // back-to-back: start held high, second operation accepted in the DONE cycle
        @(negedge clock);
        a = 32'hFFFF_FFFF; b = 32'h0000_0001; sub = 1'b0; start = 1'b1;
        @(negedge clock);
        a = 32'h0000_0002; b = 32'h0000_0003;
        wait_done(cyc);
        check("t4_first_latency", cyc, 32'd5);
        check("t4_first_result", data_result, 32'h0000_0000);
        check("t4_first_cout", {31'd0, cout}, 32'd1);
        check("t4_first_ovf", {31'd0, overflow}, 32'd0);
        @(negedge clock);
        start = 1'b0;
        check("t4_second_busy", {31'd0, busy}, 32'd1);
        wait_done(cyc);
        check("t4_second_latency", cyc, 32'd5);
        check("t4_second_result", data_result, 32'h0000_0005);

        // start during RUN must be ignored
        @(negedge clock);
        a = 32'h0000_0010; b = 32'h0000_0020; sub = 1'b0; start = 1'b1;
        pulses = 0;
        r = '0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clock);
            if (done) begin
                pulses++;
                r = data_result;
            end
            if (i == 1) start = 1'b0;
            if (i == 2) begin
                start = 1'b1; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
            end
            if (i == 4) start = 1'b0;
        end
        check("t5_done_pulses", pulses, 32'd1);
        check("t5_result", r, 32'h0000_0030);

        // async reset in the 2nd RUN cycle
        @(negedge clock);
        a = 32'h0000_0011; b = 32'h0000_0022; sub = 1'b0; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        check("t6_partial_result", data_result, 32'h0000_0033);
        #2 resetn = 1'b0;
        #1;
        check("t6_rst_busy", {31'd0, busy}, 32'd0);
        check("t6_rst_done", {31'd0, done}, 32'd0);
        check("t6_rst_result", data_result, 32'd0);
        check("t6_rst_cout", {31'd0, cout}, 32'd0);
        check("t6_rst_ovf", {31'd0, overflow}, 32'd0);
        @(negedge clock);
        #2 resetn = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (done) pulses++;
        end
        check("t6_no_done", pulses, 32'd0);
        run_op("t6_after_reset", 32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0, 1'b0);

        repeat (3) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
